// File: rtl/dmx_out.sv
// DMX512 transmitter: BREAK, MAB, start code plus SLOT_COUNT data slots, then MBB idle.
// Define DMX_OUT_CONTINUOUS_EN to send frames back-to-back without start pulses.
module dmx_out #(
    parameter int CLKS_PER_BIT = 192,
    parameter int BREAK_BITS   = 23,
    parameter int MAB_BITS     = 3,
    parameter int SLOT_COUNT   = 512,
    parameter int MBB_BITS     = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic       chan_rd,
    output logic [8:0] chan_addr,
    input  logic [7:0] chan_data,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int TIMER_W = (CLKS_PER_BIT * BREAK_BITS > 1) ? $clog2(CLKS_PER_BIT * BREAK_BITS) : 1;
    localparam logic [TIMER_W-1:0] LAST_TICK = TIMER_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        BREAK,
        MAB,
        SLOT,
        MBB
    } state_t;

    state_t               r_state, w_stateNext;
    logic [TIMER_W-1:0]   r_timer, w_timerNext;
    logic [7:0]           r_bitCnt, w_bitCntNext;
    logic [9:0]           r_slot, w_slotNext;
    logic [7:0]           r_data, w_dataNext;
    logic                 r_tx, w_txNext;
    logic                 r_busy, w_busyNext;
    logic                 r_frameDone, w_frameDoneNext;
    logic                 r_chanRd, w_chanRdNext;
    logic                 r_rdDly;
    logic [8:0]           r_chanAddr, w_chanAddrNext;
    logic                 r_armed;
    logic                 w_go;
    logic                 w_bitEnd;
    logic [7:0]           w_curData;

    // r_armed blocks the first edge after reset release from starting a frame.
`ifdef DMX_OUT_CONTINUOUS_EN
    assign w_go = r_armed & (start | 1'b1);
`else
    assign w_go = r_armed & start;
`endif

    assign w_bitEnd  = (r_timer == LAST_TICK);
    assign w_curData = r_rdDly ? chan_data : r_data;

    always_comb begin
        w_stateNext     = r_state;
        w_timerNext     = w_bitEnd ? '0 : r_timer + TIMER_W'(1);
        w_bitCntNext    = r_bitCnt;
        w_slotNext      = r_slot;
        w_dataNext      = w_curData;
        w_txNext        = r_tx;
        w_busyNext      = r_busy;
        w_frameDoneNext = 1'b0;
        w_chanRdNext    = 1'b0;
        w_chanAddrNext  = r_chanAddr;

        case (r_state)
            IDLE: begin
                w_timerNext = '0;
                if (w_go) begin
                    w_stateNext  = BREAK;
                    w_bitCntNext = 8'd0;
                    w_txNext     = 1'b0;
                    w_busyNext   = 1'b1;
                end
            end
            BREAK: begin
                if (w_bitEnd) begin
                    if (r_bitCnt == 8'(BREAK_BITS - 1)) begin
                        w_stateNext  = MAB;
                        w_bitCntNext = 8'd0;
                        w_txNext     = 1'b1;
                    end else begin
                        w_bitCntNext = r_bitCnt + 8'd1;
                    end
                end
            end
            MAB: begin
                if (w_bitEnd) begin
                    if (r_bitCnt == 8'(MAB_BITS - 1)) begin
                        w_stateNext  = SLOT;
                        w_bitCntNext = 8'd0;
                        w_slotNext   = 10'd0;
                        w_dataNext   = 8'h00;
                        w_txNext     = 1'b0;
                    end else begin
                        w_bitCntNext = r_bitCnt + 8'd1;
                    end
                end
            end
            SLOT: begin
                // r_bitCnt is the bit being sent; tx is loaded with the next bit at its end.
                if (w_bitEnd) begin
                    if (r_bitCnt < 8'd8) begin
                        w_txNext     = w_curData[r_bitCnt[2:0]];
                        w_bitCntNext = r_bitCnt + 8'd1;
                    end else if (r_bitCnt < 8'd10) begin
                        w_txNext     = 1'b1;
                        w_bitCntNext = r_bitCnt + 8'd1;
                    end else begin
                        w_bitCntNext = 8'd0;
                        if (r_slot == 10'(SLOT_COUNT)) begin
                            w_stateNext = MBB;
                            w_txNext    = 1'b1;
                        end else begin
                            w_slotNext     = r_slot + 10'd1;
                            w_txNext       = 1'b0;
                            w_chanRdNext   = 1'b1;
                            w_chanAddrNext = r_slot[8:0];
                        end
                    end
                end
            end
            MBB: begin
                if (w_bitEnd) begin
                    if (r_bitCnt == 8'(MBB_BITS - 1)) begin
                        w_stateNext     = IDLE;
                        w_bitCntNext    = 8'd0;
                        w_busyNext      = 1'b0;
                        w_frameDoneNext = 1'b1;
                    end else begin
                        w_bitCntNext = r_bitCnt + 8'd1;
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_txNext    = 1'b1;
                w_busyNext  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_bitCnt    <= 8'd0;
            r_slot      <= 10'd0;
            r_data      <= 8'h00;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_frameDone <= 1'b0;
            r_chanRd    <= 1'b0;
            r_rdDly     <= 1'b0;
            r_chanAddr  <= 9'd0;
            r_armed     <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_timer     <= w_timerNext;
            r_bitCnt    <= w_bitCntNext;
            r_slot      <= w_slotNext;
            r_data      <= w_dataNext;
            r_tx        <= w_txNext;
            r_busy      <= w_busyNext;
            r_frameDone <= w_frameDoneNext;
            r_chanRd    <= w_chanRdNext;
            r_rdDly     <= r_chanRd;
            r_chanAddr  <= w_chanAddrNext;
            r_armed     <= 1'b1;
        end
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_frameDone;
    assign chan_rd    = r_chanRd;
    assign chan_addr  = r_chanAddr;

endmodule
